// File: rtl/uart_pkg.sv
// Shared UART constants and helpers for the board's transmit and receive paths.
package uart_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT   = 9600;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap naturally since DEPTH is a power of 2.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_s;
  logic              full_r;
  logic              empty_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // next occupancy from the accepted push/pop pair
  always_comb begin
    push_ok_s = push && !full_r;
    pop_ok_s  = pop && !empty_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_s = count_r + CW'(1'b1);
      2'b01:   count_s = count_r - CW'(1'b1);
      default: count_s = count_r;
    endcase
  end

  // pointers, count and registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r <= count_s;
      full_r  <= (count_s == CW'(DEPTH));
      empty_r <= (count_s == {CW{1'b0}});
    end
  end

  // storage write port
  always_ff @(posedge clk) begin
    if (push_ok_s) mem[wr_ptr_r] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign count   = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered serialiser.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int BAUD       = BAUD_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = ST_PARITY;
`else
  localparam tx_state_t AFTER_DATA = ST_STOP;
`endif

  tx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             txd_r;
  logic             busy_r;
  logic             live_r;
  logic             txd_s;
  logic             bit_end_s;
  logic             pop_s;
  logic             push_s;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rd_data;
  logic [CW-1:0]    fifo_count_s;
`ifdef UART_TX_PARITY_EN
  logic             par_r;
`endif

  assign tx_ready = live_r && !fifo_full;
  assign push_s   = tx_valid && tx_ready;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data (tx_data),
    .pop     (pop_s),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_s)
  );

  // pop on idle, or at the end of a stop bit so frames run back-to-back
  always_comb begin
    bit_end_s = (cnt_r == CNT_W'(DIV - 1));
    if (state_r == ST_IDLE) begin
      pop_s = !fifo_empty;
    end else if (state_r == ST_STOP && bit_end_s) begin
      pop_s = !fifo_empty;
    end else begin
      pop_s = 1'b0;
    end
  end

  // frame sequencer, baud counter and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
`ifdef UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else if (pop_s) begin
      state_r   <= ST_START;
      cnt_r     <= {CNT_W{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
      par_r     <= even_parity(fifo_rd_data);
`endif
    end else if (state_r == ST_IDLE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!bit_end_s) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
      case (state_r)
        ST_START: begin
          state_r   <= ST_DATA;
          bit_idx_r <= 3'd0;
        end
        ST_DATA: begin
          shift_r   <= {1'b0, shift_r[7:1]};
          bit_idx_r <= bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) state_r <= AFTER_DATA;
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: state_r <= ST_STOP;
`endif
        ST_STOP:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // line level for the current state
  always_comb begin
    case (state_r)
      ST_IDLE:   txd_s = 1'b1;
      ST_START:  txd_s = 1'b0;
      ST_DATA:   txd_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_s = par_r;
`endif
      ST_STOP:   txd_s = 1'b1;
      default:   txd_s = 1'b1;
    endcase
  end

  // registered outputs; live_r holds tx_ready low while rst is asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      txd_r  <= 1'b1;
      busy_r <= 1'b0;
      live_r <= 1'b0;
    end else begin
      txd_r  <= txd_s;
      busy_r <= (state_r != ST_IDLE) || (fifo_count_s != {CW{1'b0}});
      live_r <= 1'b1;
    end
  end

  assign txd        = txd_r;
  assign busy       = busy_r;
  assign fifo_count = fifo_count_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: small-divider instance for function, default instance for timing.
module tb_uart_tx_fifo;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [3:0] fifo_count;

  logic       d_rst;
  logic [7:0] d_data;
  logic       d_valid;
  logic       d_ready;
  logic       d_txd;
  logic       d_busy;
  logic [3:0] d_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .txd(txd), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo u_dut_def (
    .clk(clk), .rst(d_rst), .tx_data(d_data), .tx_valid(d_valid), .tx_ready(d_ready),
    .txd(d_txd), .busy(d_busy), .fifo_count(d_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    else if (slot == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  // Frame decoder on the small-divider line: samples mid-slot, records bytes and start times
  int         cyc = 0;
  logic       mon_act = 1'b0;
  int         mon_pos = 0;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_par = 1'b0;
  logic       mon_stop = 1'b0;
  logic [9:0] q_frame[$];
  int         q_start[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (txd == 1'b0) begin
        mon_act <= 1'b1;
        mon_pos <= 1;
        q_start.push_back(cyc);
      end
    end else begin
      if (mon_pos >= 15 && mon_pos <= 85 && (mon_pos % 10) == 5) mon_byte[(mon_pos-15)/10] <= txd;
      if (mon_pos == 95) mon_par <= txd;
      if (mon_pos == FB*10-5) mon_stop <= txd;
      if (mon_pos == FB*10-1) begin
        mon_act <= 1'b0;
        q_frame.push_back({mon_stop, mon_par, mon_byte});
      end
      mon_pos <= mon_pos + 1;
    end
  end

  initial begin
    int w;
    int lows;
    logic e;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    d_rst = 1'b1; d_valid = 1'b0; d_data = 8'h00;
    @(negedge clk); @(negedge clk);

    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", tx_ready, 0);
    chk("def_rst_ready", d_ready, 0);
    chk("def_rst_txd", d_txd, 1);
    rst = 1'b0; d_rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);
    chk("idle_txd", txd, 1);

    // single byte 0x32 pushed at edge N
    tx_data = 8'h32; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("single_count_N", fifo_count, 1);
    for (int k = 1; k <= FB*10+2; k++) begin
      @(negedge clk);
      if (k == 1) chk("single_popped", fifo_count, 0);
      e = (k < 2 || (k-2)/10 >= FB) ? 1'b1 : exp_bit(8'h32, (k-2)/10);
      chk($sformatf("single_txd_k%0d", k), txd, e);
      chk($sformatf("single_busy_k%0d", k), busy, (k <= FB*10+1) ? 1 : 0);
    end
    chk("single_frames", q_frame.size(), 1);
    q_frame.delete(); q_start.delete();

    // burst of 10 bytes; the tenth collides with a pop while full
    for (int i = 0; i < 9; i++) begin
      tx_data = 8'(i); tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_data = 8'h09;
    chk("burst_full_count", fifo_count, 8);
    chk("burst_full_ready", tx_ready, 0);
    w = 0;
    while (fifo_count == 4'd8 && w < 300) begin @(negedge clk); w++; end
    chk("collision_timeout", (w < 300) ? 1 : 0, 1);
    chk("collision_count", fifo_count, 7);
    chk("collision_ready", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("collision_accept", fifo_count, 8);
    w = 0;
    while (busy && w < 3000) begin @(negedge clk); w++; end
    chk("burst_done_timeout", (w < 3000) ? 1 : 0, 1);
    chk("burst_frames", q_frame.size(), 10);
    for (int i = 0; i < 10 && i < q_frame.size(); i++) begin
      chk($sformatf("burst_byte%0d", i), q_frame[i][7:0], i);
      chk($sformatf("burst_stop%0d", i), q_frame[i][9], 1);
      if (i > 0) chk($sformatf("burst_gap%0d", i), q_start[i] - q_start[i-1], FB*10);
    end
    q_frame.delete(); q_start.delete();

`ifdef UART_TX_PARITY_EN
    tx_data = 8'h07; tx_valid = 1'b1; @(negedge clk);
    tx_data = 8'h03; @(negedge clk);
    tx_valid = 1'b0;
    w = 0;
    while (busy && w < 1000) begin @(negedge clk); w++; end
    chk("parity_frames", q_frame.size(), 2);
    if (q_frame.size() == 2) begin
      chk("parity_07", q_frame[0][8], 1);
      chk("parity_03", q_frame[1][8], 0);
      chk("parity_stop", q_frame[1][9], 1);
    end
    q_frame.delete(); q_start.delete();
`endif

    // reset during data bit 3 with three bytes queued
    tx_data = 8'hA5; tx_valid = 1'b1; @(negedge clk);
    tx_data = 8'h11; @(negedge clk);
    tx_data = 8'h22; @(negedge clk);
    tx_data = 8'h33; @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 4; k <= 45; k++) @(negedge clk);
    chk("midrst_queued", fifo_count, 3);
    chk("midrst_bit3", txd, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_txd", txd, 1);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ready_low", tx_ready, 0);
    @(negedge clk);
    chk("midrst_ready", tx_ready, 1);
    q_frame.delete(); q_start.delete();
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("midrst_quiet", lows, 0);
    chk("midrst_no_frames", q_start.size(), 0);
    chk("midrst_busy", busy, 0);

    // default parameters: 0x41 at 50 MHz / 9600
    chk("def_ready", d_ready, 1);
    d_data = 8'h41; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    w = 0;
    while (d_txd && w < 100) begin @(negedge clk); w++; end
    chk("def_start_timeout", (w < 100) ? 1 : 0, 1);
    lows = 0;
    while (!d_txd && lows < 6000) begin @(negedge clk); lows++; end
    chk("def_start_width", lows, 5208);
    w = lows;
    while (d_busy && w < 60000) begin @(negedge clk); w++; end
    chk("def_frame_len", w, FB*5208);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
